// File: rtl/core_run_ctrl_pkg.sv
// core_run_ctrl_pkg: command, state and halt-cause encodings shared by the run controller
package core_run_ctrl_pkg;
    localparam int NUM_REGS = 32;
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [1:0] CMD_RUN = 2'd0;
    localparam logic [1:0] CMD_HALT = 2'd1;
    localparam logic [1:0] CMD_STEP = 2'd2;
    localparam logic [1:0] CMD_DUMP = 2'd3;
    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_CMD = 2'd1;
    localparam logic [1:0] CAUSE_BREAK = 2'd2;
    localparam logic [1:0] CAUSE_LIMIT = 2'd3;
    typedef enum logic [1:0] {ST_HALTED, ST_RUNNING, ST_STEP, ST_DUMP} state_t;
endpackage

// File: rtl/core_run_controller_if.sv
// core_run_controller_if: host command port and register-dump stream of the run controller
interface core_run_controller_if;
    import core_run_ctrl_pkg::*;
    logic cmd_valid;
    logic cmd_ready;
    logic [1:0] cmd_op;
    logic cmd_err;
    logic dump_valid;
    logic dump_ready;
    logic [31:0] dump_data;
    logic [IDX_W-1:0] dump_idx;
    logic dump_last;
    modport master (
        output cmd_valid, cmd_op, dump_ready,
        input cmd_ready, cmd_err, dump_valid, dump_data, dump_idx, dump_last
    );
    modport slave (
        input cmd_valid, cmd_op, dump_ready,
        output cmd_ready, cmd_err, dump_valid, dump_data, dump_idx, dump_last
    );
endinterface

// File: rtl/core_run_dump_seq.sv
// core_run_dump_seq: walks the register index 0..NUM_REGS-1 over a valid/ready stream
module core_run_dump_seq
    import core_run_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             active,
    input  logic             ready,
    output logic             valid,
    output logic             last,
    output logic             done,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] idx_q, idx_d;
    always_comb begin
        valid = active;
        last = active && idx_q == IDX_W'(NUM_REGS - 1);
        done = valid && ready && last;
        idx = idx_q;
        idx_d = start ? '0 : (valid && ready) ? (last ? '0 : idx_q + 1'b1) : idx_q;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) idx_q <= '0;
        else idx_q <= idx_d;
endmodule

// File: rtl/core_run_controller.sv
// core_run_controller: run/halt/step/dump sequencer with PC breakpoint and retired-instruction count.
// Define CORE_RUN_CTRL_LIMIT_EN to add the run_limit port that auto-halts after N instructions.
module core_run_controller
    import core_run_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter bit RESET_RUN = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    core_run_controller_if.slave bus,
    input  logic                 bp_en,
    input  logic [31:0]          bp_addr,
    input  logic [31:0]          fetch_pc,
    output logic                 core_en,
    output logic [IDX_W-1:0]     debug_reg_select,
    input  logic [31:0]          debug_reg_out,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [CNT_W-1:0]     instret
`ifdef CORE_RUN_CTRL_LIMIT_EN
    ,
    input  logic [CNT_W-1:0]     run_limit
`endif
);
    localparam state_t RST_STATE = RESET_RUN ? ST_RUNNING : ST_HALTED;
    state_t state_q, state_d;
    logic bp_armed_q, bp_armed_d, cmd_err_q, cmd_err_d;
    logic [1:0] cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic is_run, cmd_acc, halt_acc, run_acc, bp_hit, limit_hit, dump_start, dump_done;
    logic [IDX_W-1:0] dump_idx;
    assign is_run = state_q == ST_RUNNING;
    assign bus.cmd_ready = state_q == ST_HALTED || is_run;
    assign cmd_acc = bus.cmd_valid && bus.cmd_ready;
    assign halt_acc = is_run && cmd_acc && bus.cmd_op == CMD_HALT;
    assign run_acc = state_q == ST_HALTED && cmd_acc && bus.cmd_op == CMD_RUN;
    assign dump_start = state_q == ST_HALTED && cmd_acc && bus.cmd_op == CMD_DUMP;
    // bp_armed is low for the first RUNNING cycle so a resume from bp_addr commits it
    assign bp_hit = bp_en && bp_armed_q && fetch_pc == bp_addr;
    assign core_en = (is_run && !bp_hit && !halt_acc) || state_q == ST_STEP;
`ifdef CORE_RUN_CTRL_LIMIT_EN
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    assign limit_hit = is_run && core_en && run_limit != '0 && run_cnt_q == run_limit - 1'b1;
    assign run_cnt_d = run_acc ? '0 : (is_run && core_en) ? run_cnt_q + 1'b1 : run_cnt_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) run_cnt_q <= '0;
        else run_cnt_q <= run_cnt_d;
`else
    assign limit_hit = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        bp_armed_d = is_run;
        cmd_err_d = is_run && cmd_acc && (bus.cmd_op == CMD_STEP || bus.cmd_op == CMD_DUMP);
        instret_d = core_en ? instret_q + 1'b1 : instret_q;
        case (state_q)
            ST_HALTED:
                if (cmd_acc)
                    state_d = run_acc ? ST_RUNNING : bus.cmd_op == CMD_STEP ? ST_STEP : dump_start ? ST_DUMP : ST_HALTED;
            ST_RUNNING:
                if (bp_hit || halt_acc || limit_hit) begin
                    state_d = ST_HALTED;
                    cause_d = bp_hit ? CAUSE_BREAK : halt_acc ? CAUSE_CMD : CAUSE_LIMIT;
                end
            ST_STEP: begin
                state_d = ST_HALTED;
                cause_d = CAUSE_CMD;
            end
            ST_DUMP:
                if (dump_done) state_d = ST_HALTED;
            default: state_d = ST_HALTED;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= RST_STATE;
            cause_q <= CAUSE_NONE;
            bp_armed_q <= 1'b0;
            cmd_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            bp_armed_q <= bp_armed_d;
            cmd_err_q <= cmd_err_d;
            instret_q <= instret_d;
        end
    core_run_dump_seq u_dump (
        .clk    (clk),
        .reset  (reset),
        .start  (dump_start),
        .active (state_q == ST_DUMP),
        .ready  (bus.dump_ready),
        .valid  (bus.dump_valid),
        .last   (bus.dump_last),
        .done   (dump_done),
        .idx    (dump_idx)
    );
    assign bus.dump_idx = dump_idx;
    assign bus.dump_data = bus.dump_valid ? debug_reg_out : '0;
    assign debug_reg_select = bus.dump_valid ? dump_idx : '0;
    assign bus.cmd_err = cmd_err_q;
    assign halted = state_q == ST_HALTED;
    assign halt_cause = cause_q;
    assign instret = instret_q;
endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller: command table, breakpoint, dump-stream and reset checks against a PC-stepping core model
module tb_core_run_controller;
    import core_run_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    core_run_controller_if bus();
    logic bp_en;
    logic [31:0] bp_addr, fetch_pc, debug_reg_out, instret;
    logic core_en, halted;
    logic [4:0] debug_reg_select;
    logic [1:0] halt_cause;
`ifdef CORE_RUN_CTRL_LIMIT_EN
    logic [31:0] run_limit;
`endif
    core_run_controller #(.CNT_W(32), .RESET_RUN(1'b0)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .bus              (bus),
        .bp_en            (bp_en),
        .bp_addr          (bp_addr),
        .fetch_pc         (fetch_pc),
        .core_en          (core_en),
        .debug_reg_select (debug_reg_select),
        .debug_reg_out    (debug_reg_out),
        .halted           (halted),
        .halt_cause       (halt_cause),
        .instret          (instret)
`ifdef CORE_RUN_CTRL_LIMIT_EN
        ,
        .run_limit        (run_limit)
`endif
    );
    function automatic logic [31:0] reg_val(input logic [4:0] i);
        return 32'hC0DE0000 ^ ({27'd0, i} * 32'h00011111);
    endfunction
    always @(posedge clk or negedge rst_n)
        if (!rst_n) fetch_pc <= '0;
        else if (core_en) fetch_pc <= fetch_pc + 32'd4;
    assign debug_reg_out = reg_val(debug_reg_select);
    int n_chk = 0;
    int n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic issue(input logic [1:0] op, output logic err);
        int b = 0;
        while (!bus.cmd_ready && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_op = op;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        err = bus.cmd_err;
    endtask
    typedef struct {
        logic [1:0] op;
        int         waitn;
        logic       err;
        logic       hlt;
        logic [1:0] cause;
        int         ret;
    } row_t;
    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } dw_t;
    row_t tbl[11];
    row_t exp_q[$];
    dw_t dq[$];
    row_t r;
    dw_t d;
    logic err, stalled;
    logic [4:0] h_idx;
    logic [31:0] h_data;
    int b, c;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end
    initial begin
        tbl[0]  = '{CMD_STEP, 1, 1'b0, 1'b1, CAUSE_CMD, 1};
        tbl[1]  = '{CMD_STEP, 1, 1'b0, 1'b1, CAUSE_CMD, 2};
        tbl[2]  = '{CMD_STEP, 1, 1'b0, 1'b1, CAUSE_CMD, 3};
        tbl[3]  = '{CMD_HALT, 1, 1'b0, 1'b1, CAUSE_CMD, 3};
        tbl[4]  = '{CMD_RUN,  3, 1'b0, 1'b0, CAUSE_CMD, 6};
        tbl[5]  = '{CMD_RUN,  2, 1'b0, 1'b0, CAUSE_CMD, 9};
        tbl[6]  = '{CMD_DUMP, 2, 1'b1, 1'b0, CAUSE_CMD, 12};
        tbl[7]  = '{CMD_STEP, 1, 1'b1, 1'b0, CAUSE_CMD, 14};
        tbl[8]  = '{CMD_HALT, 1, 1'b0, 1'b1, CAUSE_CMD, 14};
        tbl[9]  = '{CMD_RUN,  2, 1'b0, 1'b0, CAUSE_CMD, 16};
        tbl[10] = '{CMD_HALT, 0, 1'b0, 1'b1, CAUSE_CMD, 16};
        bus.cmd_valid = 1'b0;
        bus.cmd_op = CMD_RUN;
        bus.dump_ready = 1'b0;
        bp_en = 1'b0;
        bp_addr = '0;
`ifdef CORE_RUN_CTRL_LIMIT_EN
        run_limit = '0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_cause", 32'(halt_cause), 32'(CAUSE_NONE));
        check("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
        check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(tbl[i]);
            issue(tbl[i].op, err);
            repeat (tbl[i].waitn) @(negedge clk);
            r = exp_q.pop_front();
            check($sformatf("row%0d_cmd_err", i), 32'(err), 32'(r.err));
            check($sformatf("row%0d_halted", i), 32'(halted), 32'(r.hlt));
            check($sformatf("row%0d_cause", i), 32'(halt_cause), 32'(r.cause));
            check($sformatf("row%0d_instret", i), instret, 32'(r.ret));
            check($sformatf("row%0d_pc", i), fetch_pc, 32'(r.ret * 4));
            if (r.waitn > 0) check($sformatf("row%0d_err_cleared", i), 32'(bus.cmd_err), 32'd0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("rerst_instret", instret, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bp_en = 1'b1;
        bp_addr = 32'h10;
        issue(CMD_RUN, err);
        b = 0;
        while (!halted && b < 20) begin
            if (fetch_pc == 32'h10) check("bp_core_en_gated", 32'(core_en), 32'd0);
            @(negedge clk);
            b++;
        end
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_cause", 32'(halt_cause), 32'(CAUSE_BREAK));
        check("bp_instret", instret, 32'd4);
        check("bp_pc", fetch_pc, 32'h10);
        issue(CMD_RUN, err);
        repeat (2) @(negedge clk);
        check("bp_resume_instret", instret, 32'd6);
        check("bp_resume_pc", fetch_pc, 32'h18);
        check("bp_resume_running", 32'(halted), 32'd0);
        issue(CMD_HALT, err);
        check("bp_halt_cmd_cause", 32'(halt_cause), 32'(CAUSE_CMD));
        bp_addr = 32'h20;
        issue(CMD_RUN, err);
        repeat (2) @(negedge clk);
        issue(CMD_HALT, err);
        check("bp_and_halt_cause", 32'(halt_cause), 32'(CAUSE_BREAK));
        check("bp_and_halt_instret", instret, 32'd8);
        check("bp_and_halt_pc", fetch_pc, 32'h20);
        bp_en = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) dq.push_back('{5'(i), reg_val(5'(i)), i == NUM_REGS - 1});
        issue(CMD_DUMP, err);
        check("dump_cmd_err", 32'(err), 32'd0);
        check("dump_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        c = 0;
        stalled = 1'b0;
        while (dq.size() != 0 && c < 300) begin
            if (stalled) begin
                check("dump_hold_valid", 32'(bus.dump_valid), 32'd1);
                check("dump_hold_idx", 32'(bus.dump_idx), 32'(h_idx));
                check("dump_hold_data", bus.dump_data, h_data);
            end
            bus.dump_ready = (c % 4 == 0) || (c % 4 == 3);
            if (bus.dump_valid && bus.dump_ready) begin
                d = dq.pop_front();
                check("dump_idx", 32'(bus.dump_idx), 32'(d.idx));
                check("dump_data", bus.dump_data, d.data);
                check("dump_last", 32'(bus.dump_last), 32'(d.last));
                stalled = 1'b0;
            end else begin
                stalled = bus.dump_valid;
                h_idx = bus.dump_idx;
                h_data = bus.dump_data;
            end
            @(negedge clk);
            c++;
        end
        bus.dump_ready = 1'b0;
        check("dump_drained", 32'(dq.size()), 32'd0);
        check("dump_end_halted", 32'(halted), 32'd1);
        check("dump_end_valid", 32'(bus.dump_valid), 32'd0);
        check("dump_end_select", 32'(debug_reg_select), 32'd0);
        check("dump_end_instret", instret, 32'd8);
        issue(CMD_DUMP, err);
        bus.dump_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.dump_ready = 1'b0;
        check("middump_idx", 32'(bus.dump_idx), 32'd3);
        rst_n = 1'b0;
        #1;
        check("middump_rst_halted", 32'(halted), 32'd1);
        check("middump_rst_valid", 32'(bus.dump_valid), 32'd0);
        check("middump_rst_idx", 32'(bus.dump_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("postrst_cause", 32'(halt_cause), 32'(CAUSE_NONE));
`ifdef CORE_RUN_CTRL_LIMIT_EN
        run_limit = 32'd5;
        issue(CMD_RUN, err);
        b = 0;
        while (!halted && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("limit_halted", 32'(halted), 32'd1);
        check("limit_cause", 32'(halt_cause), 32'(CAUSE_LIMIT));
        check("limit_instret", instret, 32'd5);
        run_limit = 32'd0;
        issue(CMD_RUN, err);
        repeat (20) @(negedge clk);
        check("nolimit_running", 32'(halted), 32'd0);
        check("nolimit_instret", instret, 32'd25);
        issue(CMD_HALT, err);
        check("nolimit_halt_cause", 32'(halt_cause), 32'(CAUSE_CMD));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
